// File: rtl/dcache_resp_pkg.sv
// dcache_resp_pkg: default sizing, derived index widths and the response queue entry shared by the responder.
package dcache_resp_pkg;
  localparam int DEF_NUM_REQS       = 4;
  localparam int DEF_WORD_SIZE      = 4;
  localparam int DEF_TAG_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH     = 30;
  localparam int DEF_DEPTH          = 256;
  localparam int DEF_LATENCY        = 2;
  localparam int DEF_RSP_QUEUE_SIZE = 4;
  localparam int MEM_IDX_W          = $clog2(DEF_DEPTH);
  localparam int QPTR_W             = $clog2(DEF_RSP_QUEUE_SIZE);
  typedef struct packed {
    logic [DEF_NUM_REQS-1:0]    tmask;
    logic [DEF_WORD_SIZE*8-1:0] data;
    logic [DEF_TAG_WIDTH-1:0]   tag;
  } rsp_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; priority starts just after the last accepted lane.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] grant_o
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  logic [W-1:0] last_q, idx;
  logic         hit;
  // Scan farthest-first so the nearest requester after last_q wins.
  always_comb begin
    hit = 1'b0;
    idx = last_q;
    for (int k = N; k >= 1; k--)
      if (req_i[(int'(last_q) + k) % N]) begin
        idx = W'((int'(last_q) + k) % N);
        hit = 1'b1;
      end
    grant_o = hit ? (N'(1) << idx) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= W'(N - 1);
    else if (adv_i && hit) last_q <= idx;
endmodule

// File: rtl/dcache_req_responder.sv
// dcache_req_responder: single-port word memory behind a per-lane dcache request bus,
// returning read data in order through a fixed-latency pipe and a credit-bounded response queue.
module dcache_req_responder
  import dcache_resp_pkg::*;
#(
  parameter int NUM_REQS       = DEF_NUM_REQS,
  parameter int WORD_SIZE      = DEF_WORD_SIZE,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int LATENCY        = DEF_LATENCY,
  parameter int RSP_QUEUE_SIZE = DEF_RSP_QUEUE_SIZE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]   req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQS*WORD_SIZE*8-1:0] req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQS-1:0]             req_ready,
  output logic                            rsp_valid,
  output logic [NUM_REQS-1:0]             rsp_tmask,
  output logic [WORD_SIZE*8-1:0]          rsp_data,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  input  logic                            rsp_ready
);
  localparam int DW = WORD_SIZE * 8;
  localparam int IW = $clog2(DEPTH);
  localparam int QW = $clog2(RSP_QUEUE_SIZE);
  logic [NUM_REQS-1:0]   eligible, grant;
  logic [QW:0]           cred_q, cnt_q;
  logic [QW-1:0]         wp_q, rp_q;
  logic                  credit_ok, accept, rd_acc, push_v, pop, unused_addr;
  logic                  sel_rw;
  logic [WORD_SIZE-1:0]  sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DW-1:0]         sel_data;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DW-1:0]         mem [DEPTH];
  rsp_entry_t            in_e, push_e, head;
  rsp_entry_t            q_mem [RSP_QUEUE_SIZE];
  // Credits cover both the pipe and the queue, so a granted read always has a slot waiting.
  assign credit_ok = cred_q < (QW+1)'(RSP_QUEUE_SIZE);
  assign eligible  = req_valid & (req_rw | {NUM_REQS{credit_ok}});
  rr_arbiter #(.N(NUM_REQS)) u_arb (
    .clk     (clk),
    .rst     (reset),
    .req_i   (eligible),
    .adv_i   (accept),
    .grant_o (grant)
  );
  assign req_ready = reset ? '0 : grant;
  assign accept    = |req_ready;
  always_comb begin
    sel_rw   = 1'b0;
    sel_be   = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_REQS; i++)
      if (grant[i]) begin
        sel_rw   = req_rw[i];
        sel_be   = req_byteen[i*WORD_SIZE +: WORD_SIZE];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DW +: DW];
        sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
  end
  assign rd_acc      = accept && !sel_rw;
  assign unused_addr = ^sel_addr[ADDR_WIDTH-1:IW];
  assign in_e        = '{tmask: grant, data: mem[sel_addr[IW-1:0]], tag: sel_tag};
  always_ff @(posedge clk)
    if (accept && sel_rw)
      for (int b = 0; b < WORD_SIZE; b++)
        if (sel_be[b]) mem[sel_addr[IW-1:0]][b*8 +: 8] <= sel_data[b*8 +: 8];
  // The queue write itself is the last latency stage, so the pipe holds LATENCY-1 registers.
  if (LATENCY == 1) begin : g_direct
    assign push_v = rd_acc;
    assign push_e = in_e;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_q;
    rsp_entry_t         pe_q [LATENCY-1];
    always_ff @(posedge clk or posedge reset)
      if (reset) pv_q <= '0;
      else pv_q <= (LATENCY-1)'({pv_q, rd_acc});
    always_ff @(posedge clk) begin
      pe_q[0] <= in_e;
      for (int j = 1; j < LATENCY - 1; j++) pe_q[j] <= pe_q[j-1];
    end
    assign push_v = pv_q[LATENCY-2];
    assign push_e = pe_q[LATENCY-2];
  end
  assign pop = rsp_valid && rsp_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      cred_q <= '0;
    end else begin
      wp_q   <= wp_q + QW'(push_v);
      rp_q   <= rp_q + QW'(pop);
      cnt_q  <= cnt_q + (QW+1)'(push_v) - (QW+1)'(pop);
      cred_q <= cred_q + (QW+1)'(rd_acc) - (QW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push_v) q_mem[wp_q] <= push_e;
  assign head      = q_mem[rp_q];
  assign rsp_valid = cnt_q != '0;
  assign rsp_tmask = rsp_valid ? head.tmask : '0;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_tag   = rsp_valid ? head.tag : '0;
endmodule

// File: tb/tb_dcache_req_responder.sv
// tb_dcache_req_responder: directed bring-up of the responder with hand-computed responses.
module tb_dcache_req_responder;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0, req_rw = '0;
  logic [15:0]  req_byteen = '0;
  logic [119:0] req_addr = '0;
  logic [127:0] req_data = '0;
  logic [31:0]  req_tag = '0;
  logic [3:0]   req_ready, rsp_tmask;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [7:0]   rsp_tag;
  logic         rsp_ready = 1'b1;
  int           n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  dcache_req_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_byteen (req_byteen),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_tmask  (rsp_tmask),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic rw, input logic [3:0] be,
                          input logic [29:0] a, input logic [31:0] d, input logic [7:0] t);
    req_valid[i]         = v;
    req_rw[i]            = rw;
    req_byteen[i*4 +: 4] = be;
    req_addr[i*30 +: 30] = a;
    req_data[i*32 +: 32] = d;
    req_tag[i*8 +: 8]    = t;
  endtask

  always @(negedge clk)
    if (!reset) begin
      n_assert++;
      assert (!(dut.push_v && dut.cnt_q == 3'd4)) else begin
        n_fail++;
        $error("FAIL queue_overflow: observed push with occupancy %0d, expected no push when full", dut.cnt_q);
      end
    end

  initial begin
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tmask", rsp_tmask, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    req_valid = '0;
    reset = 1'b0;
    cyc();
    // write-then-read, lane 0
    set_lane(0, 1, 1, 4'hF, 30'h10, 32'hDEADBEEF, 8'h00); #1;
    chk("t1_wr_ready", req_ready, 4'b0001);
    cyc();
    set_lane(0, 1, 0, 4'h0, 30'h10, 32'h0, 8'h5A); #1;
    chk("t1_rd_ready", req_ready, 4'b0001);
    chk("t1_rsp_early0", rsp_valid, 0);
    cyc();
    req_valid = '0; #1;
    chk("t1_rsp_early1", rsp_valid, 0);
    cyc();
    #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("t1_rsp_tmask", rsp_tmask, 4'b0001);
    chk("t1_rsp_tag", rsp_tag, 8'h5A);
    cyc();
    #1;
    chk("t1_rsp_drained", rsp_valid, 0);
    cyc();
    // lane 3 write leaves last_grant on lane 3 so lane 0 leads the next round
    set_lane(3, 1, 1, 4'hF, 30'h20, 32'hCAFEF00D, 8'h00); #1;
    chk("t2_wr_ready", req_ready, 4'b1000);
    cyc();
    for (int i = 0; i < 4; i++) set_lane(i, 1, 0, 4'h0, 30'h20, 32'h0, 8'(i + 1));
    for (int c = 0; c < 7; c++) begin
      req_valid = 4'hF << c; #1;
      chk("t2_grant", req_ready, (c < 4) ? 4'(1 << c) : 4'h0);
      chk("t2_rsp_valid", rsp_valid, (c >= 2 && c < 6) ? 1 : 0);
      chk("t2_rsp_tmask", rsp_tmask, (c >= 2 && c < 6) ? 4'(1 << (c - 2)) : 4'h0);
      chk("t2_rsp_tag", rsp_tag, (c >= 2 && c < 6) ? 8'(c - 1) : 8'h0);
      chk("t2_rsp_data", rsp_data, (c >= 2 && c < 6) ? 32'hCAFEF00D : 32'h0);
      cyc();
    end
    // backpressure: only RSP_QUEUE_SIZE reads outstanding, writes still flow
    rsp_ready = 1'b0;
    set_lane(0, 1, 0, 4'h0, 30'h10, 32'h0, 8'h30);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_rd_accept", req_ready, 4'b0001);
      cyc();
    end
    #1;
    chk("t3_credit_block", req_ready, 4'b0000);
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_tag", rsp_tag, 8'h30);
    cyc();
    set_lane(1, 1, 1, 4'hF, 30'h30, 32'h12345678, 8'h00); #1;
    chk("t3_wr_bypass", req_ready, 4'b0010);
    cyc();
    req_valid[1] = 1'b0; #1;
    chk("t3_still_blocked", req_ready, 4'b0000);
    chk("t3_rsp_hold", rsp_data, 32'hDEADBEEF);
    cyc();
    rsp_ready = 1'b1; #1;
    chk("t3_pop_no_same_cycle_credit", req_ready, 4'b0000);
    chk("t3_rsp_valid_pop", rsp_valid, 1);
    cyc();
    req_tag[7:0] = 8'h31; #1;
    chk("t3_reads_resume", req_ready, 4'b0001);
    chk("t3_rsp_tag2", rsp_tag, 8'h30);
    cyc();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_drain_valid", rsp_valid, (k < 3) ? 1 : 0);
      chk("t3_drain_tag", rsp_tag, (k < 2) ? 8'h30 : ((k == 2) ? 8'h31 : 8'h00));
      cyc();
    end
    // partial write, then all-zero byteen no-op
    set_lane(2, 1, 1, 4'hF, 30'h5, 32'h11223344, 8'h00); #1;
    chk("t4_wr_ready", req_ready, 4'b0100);
    cyc();
    set_lane(2, 1, 1, 4'h2, 30'h5, 32'h0000AA00, 8'h00); #1;
    cyc();
    set_lane(2, 1, 1, 4'h0, 30'h5, 32'hFFFFFFFF, 8'h00); #1;
    chk("t4_zero_be_accept", req_ready, 4'b0100);
    cyc();
    set_lane(2, 1, 0, 4'h0, 30'h5, 32'h0, 8'h44); #1;
    cyc();
    req_valid = '0; #1;
    cyc();
    #1;
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_data", rsp_data, 32'h1122AA44);
    chk("t4_rsp_tmask", rsp_tmask, 4'b0100);
    chk("t4_rsp_tag", rsp_tag, 8'h44);
    cyc();
    // address alias: 0x105 and 0x005 share a word
    set_lane(3, 1, 1, 4'hF, 30'h105, 32'hA5A55A5A, 8'h00); #1;
    cyc();
    set_lane(3, 1, 0, 4'h0, 30'h005, 32'h0, 8'h55); #1;
    cyc();
    req_valid = '0;
    set_lane(1, 1, 0, 4'h0, 30'h30, 32'h0, 8'h66); #1;
    cyc();
    req_valid = '0; #1;
    chk("t5_alias_data", rsp_data, 32'hA5A55A5A);
    chk("t5_alias_tmask", rsp_tmask, 4'b1000);
    chk("t5_alias_tag", rsp_tag, 8'h55);
    cyc();
    #1;
    chk("t5_lane1_wr_data", rsp_data, 32'h12345678);
    chk("t5_lane1_tmask", rsp_tmask, 4'b0010);
    chk("t5_lane1_tag", rsp_tag, 8'h66);
    cyc();
    // reset with reads in flight
    set_lane(0, 1, 0, 4'h0, 30'h10, 32'h0, 8'h70); #1;
    chk("t6_rd0_ready", req_ready, 4'b0001);
    cyc();
    req_tag[7:0] = 8'h71; #1;
    cyc();
    req_valid = '0;
    reset = 1'b1; #1;
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_rsp_data", rsp_data, 0);
    chk("t6_rst_rsp_tag", rsp_tag, 0);
    cyc();
    reset = 1'b0; #1;
    chk("t6_post_rst_valid0", rsp_valid, 0);
    cyc();
    #1;
    chk("t6_post_rst_valid1", rsp_valid, 0);
    cyc();
    rsp_ready = 1'b0;
    set_lane(0, 1, 0, 4'h0, 30'h10, 32'h0, 8'h80);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t6_credit_restored", req_ready, 4'b0001);
      cyc();
    end
    #1;
    chk("t6_credit_limit", req_ready, 4'b0000);
    chk("t6_mem_retained", rsp_data, 32'hDEADBEEF);
    chk("t6_rsp_tag", rsp_tag, 8'h80);
    cyc();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) cyc();
    #1;
    chk("t6_final_empty", rsp_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
